// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//
// Round-robin arbiter and sequencer that shares one uart_tx transmitter between
// N_REQ byte producers. One byte is accepted at a time and launched with a
// single-cycle data-valid pulse. The block then waits for the transmitter's
// done pulse (or a timeout) and inserts an idle gap before the next launch.
//
// Ports
//   i_clk        system clock, all logic on the rising edge
//   i_rst        synchronous, active-high reset
//   i_req        per-requester request, held with its byte until o_ack
//   i_req_byte   requester k's byte on bits [8k+7:8k]
//   o_ack        one-hot 1-cycle pulse: requester k's byte accepted/launched
//   o_done       one-hot 1-cycle pulse: requester k's frame fully transmitted
//   o_err        1-cycle pulse: transmitter did not report done in time
//   o_busy       high whenever the sequencer is not idle
//   o_grant_id   index of the last/current granted requester
//   o_tx_dv      to uart_tx i_tx_dv, 1-cycle launch pulse
//   o_tx_byte    to uart_tx i_tx_byte, held from launch until next launch
//   i_tx_active  from uart_tx o_tx_active
//   i_tx_done    from uart_tx o_tx_done
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter int N_REQ        = 4,
    parameter int GAP_CLKS     = 16,
    parameter int TIMEOUT_CLKS = 1024
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic [N_REQ-1:0]           i_req,
    input  logic [8*N_REQ-1:0]         i_req_byte,
    output logic [N_REQ-1:0]           o_ack,
    output logic [N_REQ-1:0]           o_done,
    output logic                       o_err,
    output logic                       o_busy,
    output logic [$clog2(N_REQ)-1:0]   o_grant_id,
    output logic                       o_tx_dv,
    output logic [7:0]                 o_tx_byte,
    input  logic                       i_tx_active,
    input  logic                       i_tx_done
);

    localparam int ID_W  = $clog2(N_REQ);
    localparam int TO_W  = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
    localparam int GAP_W = (GAP_CLKS > 1) ? $clog2(GAP_CLKS) : 1;

    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CLKS - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CLKS > 0) ? GAP_CLKS - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_DONE = 2'd1,
        S_GAP       = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [ID_W-1:0]     ptr_q, ptr_d;
    logic [ID_W-1:0]     grant_q, grant_d;
    logic [7:0]          byte_q, byte_d;
    logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
    logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;
    logic [N_REQ-1:0]    ack_q, ack_d;
    logic [N_REQ-1:0]    done_q, done_d;
    logic                err_q, err_d;
    logic                dv_q, dv_d;

    logic                win_found;
    logic [ID_W-1:0]     win_id;

    // Rotating priority search: the first requester at or after the pointer,
    // wrapping modulo N_REQ, wins. Handles non-power-of-two N_REQ.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        for (int s = 0; s < N_REQ; s++) begin
            int idx;
            idx = int'(ptr_q) + s;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (!win_found && i_req[idx]) begin
                win_found = 1'b1;
                win_id    = ID_W'(idx);
            end
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        grant_d   = grant_q;
        byte_d    = byte_q;
        to_cnt_d  = to_cnt_q;
        gap_cnt_d = gap_cnt_q;
        ack_d     = '0;
        done_d    = '0;
        err_d     = 1'b0;
        dv_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                // The transmitter has no reset of its own, so after a
                // mid-frame reset we must wait for the line to go idle.
                if (win_found && !i_tx_active) begin
                    state_d  = S_WAIT_DONE;
                    dv_d     = 1'b1;
                    byte_d   = i_req_byte[8*win_id +: 8];
                    ack_d    = N_REQ'(1) << win_id;
                    grant_d  = win_id;
                    ptr_d    = (int'(win_id) == N_REQ - 1) ? '0 : win_id + 1'b1;
                    to_cnt_d = '0;
                end
            end

            S_WAIT_DONE: begin
                // Done has priority over a coincident timeout.
                if (i_tx_done || (to_cnt_q == TO_LAST)) begin
                    if (i_tx_done) begin
                        done_d[grant_q] = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                    if (GAP_CLKS == 0) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d   = S_GAP;
                        gap_cnt_d = '0;
                    end
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end

            S_GAP: begin
                // Requests are ignored here; the gap lasts GAP_CLKS cycles.
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= S_IDLE;
            ptr_q     <= '0;
            grant_q   <= '0;
            byte_q    <= '0;
            to_cnt_q  <= '0;
            gap_cnt_q <= '0;
            ack_q     <= '0;
            done_q    <= '0;
            err_q     <= 1'b0;
            dv_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            grant_q   <= grant_d;
            byte_q    <= byte_d;
            to_cnt_q  <= to_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            ack_q     <= ack_d;
            done_q    <= done_d;
            err_q     <= err_d;
            dv_q      <= dv_d;
        end
    end

    assign o_ack      = ack_q;
    assign o_done     = done_q;
    assign o_err      = err_q;
    assign o_tx_dv    = dv_q;
    assign o_tx_byte  = byte_q;
    assign o_grant_id = grant_q;
    assign o_busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_uart_tx_arbiter
//
// Two arbiters side by side: instance 0 with GAP_CLKS=4 and an 87 clk/bit
// transmitter model, instance 1 with GAP_CLKS=0 and an 8 clk/bit model.
// A timestamp-based reference model predicts every output each cycle; a
// serial receiver checks the bytes that appear on each line.
// -----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

    localparam int NR    = 4;
    localparam int TMO   = 1024;
    localparam int GAP_A = 4;
    localparam int GAP_B = 0;
    localparam int CPB_A = 87;
    localparam int CPB_B = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [3:0] req   [2];
    logic [31:0] rbyte [2];
    logic [3:0] ack   [2];
    logic [3:0] done  [2];
    logic       err   [2];
    logic       busy  [2];
    logic [1:0] gid   [2];
    logic       dv    [2];
    logic [7:0] txb   [2];
    logic       tx_act  [2] = '{1'b0, 1'b0};
    logic       tx_done [2] = '{1'b0, 1'b0};
    logic       line    [2] = '{1'b1, 1'b1};

    uart_tx_arbiter #(.N_REQ(NR), .GAP_CLKS(GAP_A), .TIMEOUT_CLKS(TMO)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_req(req[0]), .i_req_byte(rbyte[0]),
        .o_ack(ack[0]), .o_done(done[0]), .o_err(err[0]), .o_busy(busy[0]),
        .o_grant_id(gid[0]), .o_tx_dv(dv[0]), .o_tx_byte(txb[0]),
        .i_tx_active(tx_act[0]), .i_tx_done(tx_done[0])
    );

    uart_tx_arbiter #(.N_REQ(NR), .GAP_CLKS(GAP_B), .TIMEOUT_CLKS(TMO)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_req(req[1]), .i_req_byte(rbyte[1]),
        .o_ack(ack[1]), .o_done(done[1]), .o_err(err[1]), .o_busy(busy[1]),
        .o_grant_id(gid[1]), .o_tx_dv(dv[1]), .o_tx_byte(txb[1]),
        .i_tx_active(tx_act[1]), .i_tx_done(tx_done[1])
    );

    // Behavioural transmitters (no reset, like the real uart_tx). When muted
    // they ignore launches entirely and never report done.
    bit         mute = 1'b0;
    int         tcnt  [2] = '{0, 0};
    int         tbit  [2] = '{0, 0};
    logic [9:0] tsh   [2];
    logic       tbusy [2] = '{1'b0, 1'b0};

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!tbusy[i]) begin
                tx_done[i] <= 1'b0;
                if (dv[i] === 1'b1 && !mute) begin
                    tbusy[i]  <= 1'b1;
                    tsh[i]    <= {1'b1, txb[i], 1'b0};
                    tcnt[i]   <= 0;
                    tbit[i]   <= 0;
                    tx_act[i] <= 1'b1;
                    line[i]   <= 1'b0;
                end
            end else if (tcnt[i] == ((i == 0) ? CPB_A : CPB_B) - 1) begin
                tcnt[i] <= 0;
                if (tbit[i] == 9) begin
                    tbusy[i]   <= 1'b0;
                    tx_act[i]  <= 1'b0;
                    tx_done[i] <= 1'b1;
                    line[i]    <= 1'b1;
                end else begin
                    tbit[i] <= tbit[i] + 1;
                    line[i] <= tsh[i][tbit[i] + 1];
                end
            end else begin
                tcnt[i] <= tcnt[i] + 1;
            end
        end
    end

    // Bench bookkeeping
    int         n_chk = 0;
    int         n_bad = 0;
    int         nedge = 0;
    logic [7:0] pend [8][$];
    int         ord  [2][$];
    logic [7:0] rxq  [2][$];
    int         errs_seen  [2];
    int         dones_seen [2];

    // Reference model state: frames in flight and timestamps of edges
    int         m_frame  [2];
    int         m_free   [2];
    int         m_launch [2];
    int         m_ptr    [2];
    int         m_gid    [2];
    logic [3:0] m_ack    [2];
    logic [3:0] m_done   [2];
    logic       m_err    [2];
    logic       m_dv     [2];
    logic       m_busy   [2];
    logic [7:0] m_byte   [2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic drive_reqs();
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < 4; k++) begin
                req[i][k] = (pend[i*4+k].size() != 0);
                rbyte[i][8*k +: 8] = req[i][k] ? pend[i*4+k][0] : 8'h00;
            end
        end
    endtask

    // Predict the outputs produced by edge number nedge from current inputs.
    task automatic predict(input int i);
        int gap;
        int k;
        gap = (i == 0) ? GAP_A : GAP_B;
        m_ack[i]  = '0;
        m_done[i] = '0;
        m_err[i]  = 1'b0;
        m_dv[i]   = 1'b0;
        if (rst) begin
            m_frame[i] = 0;
            m_free[i]  = nedge + 1;
            m_ptr[i]   = 0;
            m_gid[i]   = 0;
            m_byte[i]  = 8'h00;
        end else if (m_frame[i] != 0) begin
            if (tx_done[i] || (nedge - m_launch[i] == TMO)) begin
                if (tx_done[i]) m_done[i] = 4'b0001 << m_gid[i];
                else            m_err[i]  = 1'b1;
                m_frame[i] = 0;
                m_free[i]  = nedge + gap + 1;
            end
        end else if (nedge >= m_free[i] && req[i] != 4'b0 && !tx_act[i]) begin
            k = -1;
            for (int s = 0; s < 4; s++) begin
                if (k < 0 && req[i][(m_ptr[i] + s) % 4]) k = (m_ptr[i] + s) % 4;
            end
            m_ack[i]    = 4'b0001 << k;
            m_dv[i]     = 1'b1;
            m_byte[i]   = rbyte[i][8*k +: 8];
            m_gid[i]    = k;
            m_ptr[i]    = (k + 1) % 4;
            m_frame[i]  = 1;
            m_launch[i] = nedge;
            if (!mute) rxq[i].push_back(m_byte[i]);
        end
        m_busy[i] = (m_frame[i] != 0) || (m_free[i] > nedge + 1);
    endtask

    task automatic step();
        logic [31:0] got;
        logic [31:0] exp;
        drive_reqs();
        predict(0);
        predict(1);
        @(posedge clk);
        nedge++;
        #1;
        for (int i = 0; i < 2; i++) begin
            got = {11'b0, ack[i], done[i], err[i], busy[i], gid[i], dv[i], txb[i]};
            exp = {11'b0, m_ack[i], m_done[i], m_err[i], m_busy[i], 2'(m_gid[i]), m_dv[i], m_byte[i]};
            check((i == 0) ? "cyc_a" : "cyc_b", got, exp);
            for (int k = 0; k < 4; k++) begin
                if (ack[i][k] === 1'b1) begin
                    if (pend[i*4+k].size() != 0) void'(pend[i*4+k].pop_front());
                    ord[i].push_back(k);
                end
            end
            if (err[i] === 1'b1) errs_seen[i]++;
            if (done[i] != 4'b0) dones_seen[i]++;
        end
    endtask

    function automatic bit all_idle();
        for (int i = 0; i < 2; i++) begin
            if (m_frame[i] != 0 || m_free[i] > nedge || tbusy[i]) return 1'b0;
            for (int k = 0; k < 4; k++) begin
                if (pend[i*4+k].size() != 0) return 1'b0;
            end
        end
        return 1'b1;
    endfunction

    task automatic run_idle(input int budget, input string tag);
        int n;
        n = 0;
        while (!all_idle() && n < budget) begin
            step();
            n++;
        end
        check(tag, 32'(all_idle()), 32'd1);
    endtask

    function automatic logic [31:0] pack_ord(input int i);
        logic [31:0] v;
        v = '0;
        for (int j = 0; j < ord[i].size(); j++) v = (v << 4) | 32'(ord[i][j] + 1);
        return v;
    endfunction

    task automatic push_both(input int k, input logic [7:0] b);
        pend[k].push_back(b);
        pend[4+k].push_back(b);
    endtask

    task automatic clear_stats();
        for (int i = 0; i < 2; i++) begin
            ord[i].delete();
            errs_seen[i]  = 0;
            dones_seen[i] = 0;
        end
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    // Serial receiver: samples mid-bit and compares against launched bytes.
    task automatic rx_mon(input int i);
        int         cpb;
        logic [7:0] bb;
        logic [7:0] e;
        cpb = (i == 0) ? CPB_A : CPB_B;
        forever begin
            @(posedge clk);
            #1;
            if (line[i] == 1'b0) begin
                repeat (cpb / 2) @(posedge clk);
                #1;
                check("rx_start", 32'(line[i]), 32'd0);
                for (int b = 0; b < 8; b++) begin
                    repeat (cpb) @(posedge clk);
                    #1;
                    bb[b] = line[i];
                end
                repeat (cpb) @(posedge clk);
                #1;
                check("rx_stop", 32'(line[i]), 32'd1);
                if (rxq[i].size() != 0) e = rxq[i].pop_front();
                else                    e = ~bb;
                check((i == 0) ? "rx_byte_a" : "rx_byte_b", 32'(bb), 32'(e));
            end
        end
    endtask

    initial rx_mon(0);
    initial rx_mon(1);

    initial begin
        int         n;
        int         mask;
        logic [7:0] b;

        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            req[i] = '0; rbyte[i] = '0;
            m_frame[i] = 0; m_free[i] = 0; m_launch[i] = 0; m_ptr[i] = 0; m_gid[i] = 0;
            m_ack[i] = '0; m_done[i] = '0; m_err[i] = 1'b0; m_dv[i] = 1'b0;
            m_busy[i] = 1'b0; m_byte[i] = '0;
        end
        clear_stats();

        // Reset state
        repeat (3) step();
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check("rst_state", {ack[i], done[i], err[i], busy[i], gid[i], dv[i], txb[i]}, 32'd0);
        end

        // Single requester 2, byte A5
        push_both(2, 8'hA5);
        run_idle(3000, "p1_idle");
        check("p1_order_a", pack_ord(0), 32'h3);
        check("p1_order_b", pack_ord(1), 32'h3);
        check("p1_done_a", 32'(dones_seen[0]), 32'd1);

        // All four requesters, then pointer wrap
        pulse_reset();
        clear_stats();
        push_both(0, 8'h11); push_both(1, 8'h22); push_both(2, 8'h33); push_both(3, 8'h44);
        run_idle(8000, "p2_idle");
        push_both(1, 8'h55); push_both(0, 8'h66);
        run_idle(4000, "p2_wrap_idle");
        check("p2_order_a", pack_ord(0), 32'h123412);
        check("p2_order_b", pack_ord(1), 32'h123412);

        // Requester 1 streams three bytes, requester 3 joins after first grant
        pulse_reset();
        clear_stats();
        for (int j = 0; j < 3; j++) push_both(1, 8'($urandom));
        n = 0;
        while ((ord[0].size() == 0 || ord[1].size() == 0) && n < 50) begin
            step();
            n++;
        end
        check("p3_first_ack", 32'(ord[0].size() + ord[1].size()), 32'd2);
        push_both(3, 8'($urandom));
        run_idle(6000, "p3_idle");
        check("p3_order_a", pack_ord(0), 32'h2422);
        check("p3_order_b", pack_ord(1), 32'h2422);

        // Random request patterns, including arrivals mid-stream
        for (int r = 0; r < 3; r++) begin
            mask = $urandom_range(1, 15);
            for (int k = 0; k < 4; k++) if (mask[k]) push_both(k, 8'($urandom));
            n = $urandom_range(0, 900);
            repeat (n) step();
            mask = $urandom_range(0, 15);
            for (int k = 0; k < 4; k++) if (mask[k]) push_both(k, 8'($urandom));
            run_idle(12000, "p4_idle");
        end

        // Transmitter never reports done: timeout, then normal service
        clear_stats();
        mute = 1'b1;
        b = 8'($urandom);
        push_both(0, b);
        run_idle(3000, "p5_to_idle");
        check("p5_err_a", 32'(errs_seen[0]), 32'd1);
        check("p5_err_b", 32'(errs_seen[1]), 32'd1);
        check("p5_nodone_a", 32'(dones_seen[0] + dones_seen[1]), 32'd0);
        mute = 1'b0;
        push_both(1, 8'($urandom));
        run_idle(3000, "p5_idle");
        check("p5_done_after", 32'(dones_seen[0] + dones_seen[1]), 32'd2);
        check("p5_err_after", 32'(errs_seen[0] + errs_seen[1]), 32'd2);

        // Reset in the middle of a frame with requester 0 pending
        clear_stats();
        push_both(1, 8'($urandom));
        repeat (30) step();
        check("p6_tx_active", {30'b0, tx_act[0], tx_act[1]}, 32'h3);
        push_both(0, 8'($urandom));
        step();
        pulse_reset();
        for (int i = 0; i < 2; i++) begin
            check("p6_rst_zero", {ack[i], done[i], err[i], busy[i], gid[i], dv[i], txb[i]}, 32'd0);
        end
        run_idle(4000, "p6_idle");
        check("p6_order_a", pack_ord(0), 32'h21);
        check("p6_order_b", pack_ord(1), 32'h21);

        repeat (5) step();
        check("rxq_a_empty", 32'(rxq[0].size()), 32'd0);
        check("rxq_b_empty", 32'(rxq[1].size()), 32'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Round-robin arbiter and sequencer that shares one uart_tx transmitter between N_REQ byte-producing requesters.
- Accepts a byte from one requester at a time and pulses the transmitter's data-valid input.
- Waits for the transmitter's done pulse, then enforces a programmable inter-frame idle gap.
- Sits directly in front of uart_tx. The transmitter's i_tx_dv and i_tx_byte inputs are driven only by this block.

Parameters:
N_REQ, 4, number of requesters (2..8)
GAP_CLKS, 16, idle clocks inserted after each frame before the next launch (0 = no gap)
TIMEOUT_CLKS, 1024, max clocks in WAIT_DONE before aborting; must exceed 10*clk_per_bit (870 for 87)

Ports:
i_clk  in  1  system clock, all logic on rising edge
i_rst  in  1  synchronous, active-high reset
i_req  in  N_REQ  per-requester request; held high with its byte stable until o_ack
i_req_byte  in  8*N_REQ  requester k's byte on bits [8k+7:8k]
o_ack  out  N_REQ  one-hot, 1-cycle pulse: byte of requester k accepted and launched
o_done  out  N_REQ  one-hot, 1-cycle pulse: requester k's frame fully transmitted
o_err  out  1  1-cycle pulse: transmit timeout
o_busy  out  1  high whenever state != IDLE
o_grant_id  out  $clog2(N_REQ)  index of last/current granted requester
o_tx_dv  out  1  to uart_tx i_tx_dv, 1-cycle pulse
o_tx_byte  out  8  to uart_tx i_tx_byte, held from launch until next launch
i_tx_active  in  1  from uart_tx o_tx_active
i_tx_done  in  1  from uart_tx o_tx_done

Behaviour:
- Reset (i_rst high at a clock edge): all outputs 0 (o_tx_byte 8'h00, o_grant_id 0); state IDLE; priority pointer 0; gap and timeout counters 0. Reset overrides everything, including mid-frame.
- States: IDLE, WAIT_DONE, GAP.
- IDLE: launch only if |i_req and i_tx_active==0.
  - After a mid-frame reset the transmitter has no reset, so the arbiter stalls until the line goes idle.
  - Winner k = first set i_req bit searching ptr, ptr+1, ... modulo N_REQ.
  - On that edge register: o_tx_dv=1, o_tx_byte=i_req_byte[k], o_ack[k]=1, o_grant_id=k, ptr=(k+1) mod N_REQ, state=WAIT_DONE, timeout counter=0.
  - Latency: request sampled at edge N, o_tx_dv/o_ack visible in the cycle after edge N.
- Requester contract: it drops i_req (or presents a new byte) in the cycle after o_ack is seen. i_req is not re-sampled until IDLE, so a held request is not double-accepted.
- WAIT_DONE: o_tx_dv=0 from the second cycle on. The timeout counter increments each cycle.
  - i_tx_done==1: o_done[o_grant_id] pulses the next cycle. Then go to GAP, or to IDLE if GAP_CLKS==0.
  - Counter reaches TIMEOUT_CLKS-1 without done: o_err pulses, no o_done, next state as for done.
  - Done and timeout on the same edge: done wins, no o_err.
- GAP: count GAP_CLKS cycles, then IDLE. Requests are ignored during the gap.
- Back-to-back frames: with one requester continuously requesting, the launch-to-launch spacing is frame time + GAP_CLKS + 1 cycle.
- Fairness: any persistently requesting requester waits at most N_REQ-1 frames.
- o_ack, o_done and o_err are never multi-hot and never longer than 1 cycle.
- o_busy is combinational from state.

Test Plan:
- Reset, then requester 2 only, byte 8'hA5 (clk_per_bit=87, GAP_CLKS=4) -> o_ack=4'b0100 and o_tx_dv for exactly one cycle; o_tx_byte=8'hA5; serial line shows 0,A5 LSB-first,1; o_done=4'b0100 one cycle after i_tx_done; o_busy low 5 cycles after done.
- All four requesters held high with bytes 11,22,33,44 -> grant order 0,1,2,3, then ptr wraps to 0; each launch ≥ frame+GAP_CLKS+1 clocks apart; never two o_ack bits set.
- Requester 1 streams 3 bytes while 3 requests once mid-stream -> order 1,3,1,1 (3 served after 1's first frame).
- Stub transmitter that never asserts i_tx_done, TIMEOUT_CLKS=1024 -> o_err pulses 1024 cycles after launch; no o_done; next request is then served normally.
- i_rst asserted mid-frame while i_tx_active is still high and requester 0 is pending -> outputs zero on the next cycle; no o_tx_dv until i_tx_active falls; then requester 0 is launched.
- GAP_CLKS=0 with continuous requests -> the next o_tx_dv occurs 1 cycle after the o_done pulse cycle.
